plic_claim_ctrl: RTL and testbench
==================================

// Module: plic_claim_ctrl
// PURPOSE
//   Bus-facing register block and claim/complete sequencer for the PLIC core. Holds per-source
//   priority, enable mask and threshold and drives them into the core's config inputs. Serves
//   CPU claim reads: returns the winning source and pulses that source's int_claim. Masks claimed
//   (in-service) sources until the CPU writes completion. Drives the registered external IRQ line.
// PARAMETERS
//   PORTS          4                     number of interrupt sources (1..16)
//   ID_WIDTH       $clog2(PORTS)         core source-id width
//   PRIORITY_WIDTH $clog2(PORTS+1)       priority/threshold width; 0 = never interrupts
// PORTS
//   clk            in   1                       system clock
//   rst_n          in   1                       asynchronous active-low reset
//   req_valid      in   1                       bus request valid
//   req_ready      out  1                       bus request ready
//   req_write      in   1                       1 = write, 0 = read
//   req_addr       in   8                       byte address, word aligned
//   req_wdata      in   32                      write data
//   resp_valid     out  1                       response valid
//   resp_ready     in   1                       response ready
//   resp_rdata     out  32                      read data (0 for writes)
//   core_pending   in   1                       core: winner priority > threshold
//   core_id        in   ID_WIDTH                core: winning source id
//   int_claim      out  PORTS                   one-hot claim pulse to core
//   cfg_priority   out  PORTS*PRIORITY_WIDTH    priority of source i at [i*PW +: PW]
//   cfg_enable     out  PORTS                   enable & ~in_service
//   cfg_threshold  out  PRIORITY_WIDTH          threshold
//   ext_irq        out  1                       interrupt request to CPU
// BEHAVIOUR
//   Address map: 0x00+4*i priority[i] (i<PORTS); 0x40 enable; 0x44 threshold; 0x48 claim/complete.
//   Reset (async, all regs): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; int_claim=0;
//     priority/enable/threshold/in_service=0; ext_irq=0.
//   FSM: IDLE (req_ready=1) -accept (req_valid&req_ready)-> RESP (req_ready=0, resp_valid=1);
//     RESP -resp_ready-> IDLE. One outstanding request; resp_valid rises the cycle after accept.
//     rdata/valid hold stable in RESP until resp_ready.
//   Writes take effect at the accept edge. Priority/threshold take wdata[PW-1:0]; enable takes
//     wdata[PORTS-1:0]. Unused read bits are 0.
//   Claim (read 0x48): core_pending/core_id sampled at the accept edge.
//     If pending: rdata = core_id+1; int_claim[core_id]=1 for exactly the next cycle;
//       in_service[core_id] set.
//     Else: rdata = 0; no claim pulse.
//   Complete (write 0x48): value v in 1..PORTS clears in_service[v-1]; 0 or v>PORTS is ignored.
//     Completing a source not in service is a no-op.
//   In-service masking: cfg_enable = enable & ~in_service, so a claimed source never re-wins
//     before completion.
//   ext_irq: core_pending registered 1 cycle, forced 0 while state==RESP of a claim read.
//   Unmapped address: read returns 0; write ignored.
//   Reset mid-transaction: response dropped, nothing replayed; core sees all sources disabled.
// CONFIGURATION
//   PLIC_CTRL_ERR_EN defined: adds output resp_err (1b, valid with resp_valid, reset 0).
//     resp_err=1 for an unmapped address, or a complete write of 0/v>PORTS/v not in service.
//   Undefined: port absent; such accesses are silently ignored as above.
// STRUCTURE
//   plic_pkg: address offsets (PRIO_BASE, ENABLE_OFF, THRESH_OFF, CLAIM_OFF) and FSM state enum.
//   Sub-module plic_claim_tracker: in_service vector with set(id)/clear(id) ports and a
//     claim-pulse register.
// TESTING (PORTS=4, PRIORITY_WIDTH=3)
//   Config: write prio[2]=5, enable=0x4, threshold=1; read back 5/0x4/1;
//     cfg_priority[8:6]=5, cfg_enable=4'b0100.
//   Claim: core_pending=1, core_id=2 -> rdata=3; int_claim=4'b0100 for 1 cycle;
//     cfg_enable=4'b0000 until write 0x48<=3 restores 4'b0100.
//   Empty claim: core_pending=0, read 0x48 -> rdata=0; int_claim stays 0; in_service unchanged.
//   Backpressure: resp_ready low 5 cycles -> resp_valid held and rdata stable; req_ready=0;
//     a second req_valid is not accepted.
//   Bad complete: write 0x48<=0, then <=7 -> in_service unchanged; with PLIC_CTRL_ERR_EN,
//     resp_err=1 both times. Read 0x30 -> 0.
//   Reset: assert rst_n low during RESP -> resp_valid=0, ext_irq=0, cfg_enable=0 immediately
//     (async), req_ready=1 after release.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared definitions for the PLIC claim/complete register block:
// register offsets and the bus FSM state type.
package plic_pkg;

  localparam logic [7:0] PRIO_BASE  = 8'h00;
  localparam logic [7:0] ENABLE_OFF = 8'h40;
  localparam logic [7:0] THRESH_OFF = 8'h44;
  localparam logic [7:0] CLAIM_OFF  = 8'h48;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

endpackage

// File: rtl/plic_claim_tracker.sv
// In-service vector (set on claim, cleared on complete) and one-cycle claim pulse.
// Ports: clk, rst_n, set_en/set_id, clr_en/clr_id, in_service, int_claim.
module plic_claim_tracker #(
  parameter int PORTS    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [ID_WIDTH-1:0] set_id,
  input  logic                clr_en,
  input  logic [ID_WIDTH-1:0] clr_id,
  output logic [PORTS-1:0]    in_service,
  output logic [PORTS-1:0]    int_claim
);

  logic [PORTS-1:0] set_mask;
  logic [PORTS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < PORTS; i++) begin
      set_mask[i] = set_en && (32'(set_id) == i);
      clr_mask[i] = clr_en && (32'(clr_id) == i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_service <= '0;
      int_claim  <= '0;
    end else begin
      in_service <= (in_service | set_mask) & ~clr_mask;
      int_claim  <= set_mask;
    end
  end

endmodule

// File: rtl/plic_claim_ctrl.sv
// PLIC bus register block and claim/complete sequencer; drives core config and ext_irq.
// Ports: req_*/resp_* bus, core_pending/core_id, int_claim, cfg_*, ext_irq; resp_err if PLIC_CTRL_ERR_EN.
module plic_claim_ctrl
  import plic_pkg::*;
#(
  parameter int PORTS          = 4,
  parameter int ID_WIDTH       = (PORTS > 1) ? $clog2(PORTS) : 1,
  parameter int PRIORITY_WIDTH = $clog2(PORTS + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [7:0]                      req_addr,
  input  logic [31:0]                     req_wdata,
  output logic                            resp_valid,
  input  logic                            resp_ready,
  output logic [31:0]                     resp_rdata,
  input  logic                            core_pending,
  input  logic [ID_WIDTH-1:0]             core_id,
  output logic [PORTS-1:0]                int_claim,
  output logic [PORTS*PRIORITY_WIDTH-1:0] cfg_priority,
  output logic [PORTS-1:0]                cfg_enable,
  output logic [PRIORITY_WIDTH-1:0]       cfg_threshold,
  output logic                            ext_irq
`ifdef PLIC_CTRL_ERR_EN
  ,
  output logic                            resp_err
`endif
);

  localparam int PW = PRIORITY_WIDTH;

  state_t                   state;
  logic [PORTS-1:0][PW-1:0] prio_q;
  logic [PORTS-1:0]         enable_q;
  logic [PW-1:0]            thresh_q;
  logic [PORTS-1:0]         in_service;
  logic                     claim_q;

  logic             accept;
  logic [PORTS-1:0] prio_sel;
  logic             en_hit, th_hit, cl_hit;
  logic             cmp_ok, set_en, clr_en, claim_next;
  logic [31:0]      rd_data;

  assign accept = req_valid && req_ready;

  always_comb begin
    prio_sel = '0;
    for (int i = 0; i < PORTS; i++)
      prio_sel[i] = (req_addr == 8'(PRIO_BASE + 4 * i));
  end

  assign en_hit = (req_addr == ENABLE_OFF);
  assign th_hit = (req_addr == THRESH_OFF);
  assign cl_hit = (req_addr == CLAIM_OFF);

  assign cmp_ok = (req_wdata != 32'd0)
               && (req_wdata <= 32'(PORTS));

  // A pending id outside the source range cannot be claimed.
  assign set_en = accept && !req_write && cl_hit
               && core_pending && (32'(core_id) < PORTS);
  assign clr_en = accept && req_write && cl_hit && cmp_ok;

  // ext_irq is masked for every cycle spent in RESP of a claim read.
  assign claim_next = (accept && cl_hit && !req_write)
                   || (state == S_RESP && claim_q && !resp_ready);

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      |prio_sel: begin
        for (int i = 0; i < PORTS; i++)
          if (prio_sel[i]) rd_data = 32'(prio_q[i]);
      end
      en_hit:  rd_data = 32'(enable_q);
      th_hit:  rd_data = 32'(thresh_q);
      cl_hit:  rd_data = core_pending ? 32'(core_id) + 32'd1 : 32'd0;
      default: rd_data = '0;
    endcase
  end

`ifdef PLIC_CTRL_ERR_EN
  logic mapped, cmp_live, err_nxt;
  assign mapped   = (|prio_sel) || en_hit || th_hit || cl_hit;
  assign cmp_live = cmp_ok && in_service[ID_WIDTH'(req_wdata - 32'd1)];
  assign err_nxt  = !mapped || (cl_hit && req_write && !cmp_live);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_err <= 1'b0;
    end else if (accept) begin
      resp_err <= err_nxt;
    end else if (state == S_RESP && resp_ready) begin
      resp_err <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      prio_q     <= '0;
      enable_q   <= '0;
      thresh_q   <= '0;
      claim_q    <= 1'b0;
      ext_irq    <= 1'b0;
    end else begin
      ext_irq <= core_pending && !claim_next;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state      <= S_RESP;
            req_ready  <= 1'b0;
            resp_valid <= 1'b1;
            resp_rdata <= req_write ? 32'd0 : rd_data;
            claim_q    <= cl_hit && !req_write;
            if (req_write) begin
              for (int i = 0; i < PORTS; i++)
                if (prio_sel[i]) prio_q[i] <= req_wdata[PW-1:0];
              if (en_hit) enable_q <= req_wdata[PORTS-1:0];
              if (th_hit) thresh_q <= req_wdata[PW-1:0];
            end
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            claim_q    <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  plic_claim_tracker #(
    .PORTS   (PORTS),
    .ID_WIDTH(ID_WIDTH)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (set_en),
    .set_id    (core_id),
    .clr_en    (clr_en),
    .clr_id    (ID_WIDTH'(req_wdata - 32'd1)),
    .in_service(in_service),
    .int_claim (int_claim)
  );

  assign cfg_priority  = prio_q;
  assign cfg_enable    = enable_q & ~in_service;
  assign cfg_threshold = thresh_q;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Directed plus randomized bench for plic_claim_ctrl (PORTS=4, PRIORITY_WIDTH=3)
// checked against a register-level model of the PLIC control block.
module tb_plic_claim_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        core_pending = 1'b0;
  logic [1:0]  core_id = '0;
  logic [3:0]  int_claim;
  logic [11:0] cfg_priority;
  logic [3:0]  cfg_enable;
  logic [2:0]  cfg_threshold;
  logic        ext_irq;
`ifdef PLIC_CTRL_ERR_EN
  logic        resp_err;
`endif

  plic_claim_ctrl #(.PORTS(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .core_pending (core_pending),
    .core_id      (core_id),
    .int_claim    (int_claim),
    .cfg_priority (cfg_priority),
    .cfg_enable   (cfg_enable),
    .cfg_threshold(cfg_threshold),
    .ext_irq      (ext_irq)
`ifdef PLIC_CTRL_ERR_EN
    ,
    .resp_err     (resp_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Register-level model
  int       m_prio[4];
  int       m_en;
  int       m_th;
  bit [3:0] m_isv;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_prio[i] = 0;
    m_en = 0;
    m_th = 0;
    m_isv = '0;
  endtask

  function automatic bit is_prio(input int a);
    return (a < 16) && (a % 4 == 0);
  endfunction

  task automatic chk_cfg(input string tag);
    logic [11:0] p;
    for (int i = 0; i < 4; i++) p[i*3 +: 3] = 3'(m_prio[i]);
    chk({tag, ".prio"}, 32'(cfg_priority), 32'(p));
    chk({tag, ".en"}, 32'(cfg_enable), 32'(4'(m_en) & ~m_isv));
    chk({tag, ".th"}, 32'(cfg_threshold), 32'(m_th));
  endtask

  // One bus transaction with `hold` cycles of response backpressure.
  task automatic xact(input string tag, input bit wr, input int addr,
                      input int wd, input bit pend, input int id,
                      input int hold);
    int       exp_rd = 0;
    int       exp_cl = 0;
    bit       claim = !wr && addr == 'h48;
    bit       exp_err = 0;
    bit       mapped = is_prio(addr) || addr == 'h40
                    || addr == 'h44 || addr == 'h48;
    if (!mapped) exp_err = 1;
    if (!wr) begin
      if (is_prio(addr)) exp_rd = m_prio[addr / 4];
      else if (addr == 'h40) exp_rd = m_en;
      else if (addr == 'h44) exp_rd = m_th;
      else if (claim && pend) begin
        exp_rd = id + 1;
        exp_cl = 1 << id;
      end
    end else if (addr == 'h48) begin
      exp_err = !(wd >= 1 && wd <= 4 && m_isv[(wd - 1) & 3]);
    end
    @(negedge clk);
    chk({tag, ".rdy"}, 32'(req_ready), 32'd1);
    core_pending = pend;
    core_id = 2'(id);
    req_valid = 1'b1;
    req_write = wr;
    req_addr = 8'(addr);
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // model update at the accept edge
    if (wr) begin
      if (is_prio(addr)) m_prio[addr / 4] = wd & 7;
      else if (addr == 'h40) m_en = wd & 'hF;
      else if (addr == 'h44) m_th = wd & 7;
      else if (addr == 'h48 && wd >= 1 && wd <= 4) m_isv[wd - 1] = 1'b0;
    end else if (claim && pend) begin
      m_isv[id] = 1'b1;
    end
    chk({tag, ".vld"}, 32'(resp_valid), 32'd1);
    chk({tag, ".busy"}, 32'(req_ready), 32'd0);
    chk({tag, ".rd"}, resp_rdata, 32'(exp_rd));
    chk({tag, ".claim"}, 32'(int_claim), 32'(exp_cl));
    chk({tag, ".irq"}, 32'(ext_irq), 32'(claim ? 1'b0 : pend));
`ifdef PLIC_CTRL_ERR_EN
    chk({tag, ".err"}, 32'(resp_err), 32'(exp_err));
`endif
    chk_cfg(tag);
    for (int h = 0; h < hold; h++) begin
      // A second request must be ignored while busy.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr = 8'h44;
      req_wdata = 32'd6;
      @(posedge clk);
      #1;
      chk({tag, ".hvld"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hrd"}, resp_rdata, 32'(exp_rd));
      chk({tag, ".hrdy"}, 32'(req_ready), 32'd0);
      chk({tag, ".hcl"}, 32'(int_claim), 32'd0);
      chk({tag, ".hirq"}, 32'(ext_irq), 32'(claim ? 1'b0 : pend));
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk({tag, ".done"}, 32'(resp_valid), 32'd0);
    chk({tag, ".rdy2"}, 32'(req_ready), 32'd1);
    chk({tag, ".cl0"}, 32'(int_claim), 32'd0);
    chk({tag, ".irq2"}, 32'(ext_irq), 32'(pend));
    chk_cfg(tag);
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst.rdy", 32'(req_ready), 32'd1);
    chk("rst.vld", 32'(resp_valid), 32'd0);
    chk("rst.irq", 32'(ext_irq), 32'd0);
    chk("rst.cl", 32'(int_claim), 32'd0);
    chk_cfg("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // configuration
    xact("wp2", 1, 'h08, 5, 0, 0, 0);
    xact("wen", 1, 'h40, 'h4, 0, 0, 0);
    xact("wth", 1, 'h44, 1, 0, 0, 0);
    xact("rp2", 0, 'h08, 0, 0, 0, 0);
    xact("ren", 0, 'h40, 0, 0, 0, 0);
    xact("rth", 0, 'h44, 0, 0, 0, 0);
    chk("p2", 32'(cfg_priority[8:6]), 32'd5);
    chk("en4", 32'(cfg_enable), 32'h4);

    // claim, then complete
    xact("claim", 0, 'h48, 0, 1, 2, 0);
    chk("masked", 32'(cfg_enable), 32'h0);
    xact("cmp3", 1, 'h48, 3, 0, 0, 0);
    chk("unmask", 32'(cfg_enable), 32'h4);

    // empty claim
    xact("empty", 0, 'h48, 0, 0, 1, 0);

    // backpressure
    xact("bp", 0, 'h08, 0, 1, 0, 5);
    chk("bp.th", 32'(cfg_threshold), 32'd1);

    // bad completes and unmapped read
    xact("wenF", 1, 'h40, 'hF, 0, 0, 0);
    xact("claim1", 0, 'h48, 0, 1, 1, 0);
    xact("bad0", 1, 'h48, 0, 0, 0, 0);
    xact("bad7", 1, 'h48, 7, 0, 0, 0);
    chk("bad.en", 32'(cfg_enable), 32'hD);
    xact("r30", 0, 'h30, 0, 0, 0, 0);
    xact("cmp2", 1, 'h48, 2, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      int op = $urandom_range(0, 6);
      int hold = $urandom_range(0, 2);
      bit pend = 1'($urandom_range(0, 1));
      int id = $urandom_range(0, 3);
      int a;
      unique case (op)
        0: xact("rwp", 1, 4 * $urandom_range(0, 3), $urandom, pend, id, hold);
        1: xact("rwe", 1, 'h40, $urandom, pend, id, hold);
        2: xact("rwt", 1, 'h44, $urandom, pend, id, hold);
        3: begin
          a = 4 * $urandom_range(0, 18);
          xact("rrd", 0, a, 0, pend, id, hold);
        end
        4, 5: xact("rcl", 0, 'h48, 0, pend, id, hold);
        default: xact("rcm", 1, 'h48, $urandom_range(0, 5), pend, id, hold);
      endcase
    end

    // asynchronous reset in the middle of a claim response
    xact("wenF2", 1, 'h40, 'hF, 0, 0, 0);
    @(negedge clk);
    core_pending = 1'b1;
    core_id = 2'd3;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 8'h48;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid.vld", 32'(resp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar.vld", 32'(resp_valid), 32'd0);
    chk("ar.irq", 32'(ext_irq), 32'd0);
    chk("ar.en", 32'(cfg_enable), 32'd0);
    chk("ar.cl", 32'(int_claim), 32'd0);
    core_pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar.rdy", 32'(req_ready), 32'd1);
    chk("ar.vld2", 32'(resp_valid), 32'd0);
    xact("post", 0, 'h40, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
